// File: rtl/gf16_div_pkg.sv
// Shared types, step encoding and GF(4) subfield helpers for the serial GF(16) divider.
// Field elements use a normal basis over GF(4), so all-ones is the multiplicative identity.
package gf16_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] STEP_SQ   = 3'd0;
  localparam logic [2:0] STEP_CUBE = 3'd1;
  localparam logic [2:0] STEP_SQ6  = 3'd2;
  localparam logic [2:0] STEP_SEV  = 3'd3;
  localparam logic [2:0] STEP_SQ14 = 3'd4;
  localparam logic [2:0] STEP_FIN  = 3'd5;

  localparam logic [3:0] GF16_ONE  = 4'hF;
  localparam logic [3:0] GF16_ZERO = 4'h0;

  // GF(4) product in normal basis {W^2, W}
  function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  // Scale by the GF(16)/GF(4) norm N = W^2
  function automatic logic [1:0] gf4_mul_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/gf16_serial_div_if.sv
// Operand and result handshakes of the serial GF(16) divider.
interface gf16_serial_div_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;
  logic       div_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, div_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, div_zero
  );
endinterface

// File: rtl/Mult_GF16.sv
// Combinational GF(16) multiplier over a GF(4) tower, with an optional constant added to the product.
module Mult_GF16
  import gf16_div_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic       add_c,
  output logic [3:0] y
);

  logic [1:0] e;
  logic [1:0] p_hi;
  logic [1:0] p_lo;

  assign e    = gf4_mul_n(gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
  assign p_hi = gf4_mul(a[3:2], b[3:2]) ^ e;
  assign p_lo = gf4_mul(a[1:0], b[1:0]) ^ e;
  assign y    = {p_hi, p_lo} ^ (add_c ? c : GF16_ZERO);

endmodule

// File: rtl/gf16_serial_div.sv
// Sequential GF(16) divider: y = a * b^14 through one time-shared multiplier over six steps.
module gf16_serial_div
  import gf16_div_pkg::*;
#(
  parameter int EARLY_ZERO = 1
) (
  input logic              clk,
  input logic              rst,
  gf16_serial_div_if.slave bus
);

  state_t     state_reg, state_next;
  logic [2:0] step_reg, step_next;
  logic [3:0] ra_reg, ra_next;
  logic [3:0] rb_reg, rb_next;
  logic [3:0] t_reg, t_next;
  logic [3:0] y_reg, y_next;
  logic       dz_reg, dz_next;
  logic [3:0] mul_l, mul_r, prod;

  // Addition chain b^2, b^3, b^6, b^7, b^14, then a*b^14
  always_comb begin
    mul_l = t_reg;
    mul_r = t_reg;
    case (step_reg)
      STEP_SQ: begin
        mul_l = rb_reg;
        mul_r = rb_reg;
      end
      STEP_CUBE, STEP_SEV: mul_r = rb_reg;
      STEP_FIN:            mul_l = ra_reg;
      default: ;
    endcase
  end

  Mult_GF16 u_mult (
    .a     (mul_l),
    .b     (mul_r),
    .c     (GF16_ZERO),
    .add_c (1'b0),
    .y     (prod)
  );

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    ra_next    = ra_reg;
    rb_next    = rb_reg;
    t_next     = t_reg;
    y_next     = y_reg;
    dz_next    = dz_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          ra_next   = bus.a;
          rb_next   = bus.b;
          step_next = STEP_SQ;
          dz_next   = (bus.b == GF16_ZERO);
          if (EARLY_ZERO != 0 && bus.b == GF16_ZERO) begin
            y_next     = GF16_ZERO;
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (step_reg < STEP_FIN) begin
          t_next    = prod;
          step_next = step_reg + 3'd1;
        end else if (step_reg == STEP_FIN) begin
          y_next     = prod;
          state_next = DONE;
        end else begin
          // Unreachable step codes bail out with y untouched
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      step_reg  <= STEP_SQ;
      ra_reg    <= GF16_ZERO;
      rb_reg    <= GF16_ZERO;
      t_reg     <= GF16_ZERO;
      y_reg     <= GF16_ZERO;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      ra_reg    <= ra_next;
      rb_reg    <= rb_next;
      t_reg     <= t_next;
      y_reg     <= y_next;
      dz_reg    <= dz_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.y         = y_reg;
  assign bus.div_zero  = dz_reg;

endmodule

// File: doc/gf16_serial_div.md
# gf16_serial_div

Sequential GF(16) divider: computes y = a · b⁻¹ as a · b¹⁴ using one shared GF(16) multiplier, iterated over six cycles.

- It uses the same field representation as the datapath's existing GF(16) multiplier.
- In that representation, 4'hF is the multiplicative identity and 4'h0 is zero.
- It sits beside the inversion datapath as the unmasked reference and utility divider.
- Operands arrive and results leave over independent valid/ready handshakes.

## Interface

Parameters:
- EARLY_ZERO, default 1. When 1, a divisor of 0 skips the multiply chain. When 0, it runs the full six steps.

Ports:
- clk  input  1  system clock. One clock domain. All state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair a, b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  4  dividend.
- b  input  4  divisor.
- out_valid  output  1  y and div_zero are valid.
- out_ready  input  1  consumer accepts the result.
- y  output  4  quotient a · b¹⁴.
- div_zero  output  1  the divisor was 4'h0. y is then 4'h0.

## Operation

- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, register a into ra and b into rb; step←0.
    - If EARLY_ZERO=1 and b=0: go to DONE.
    - Otherwise: go to RUN.
  - RUN: in_ready=0. One multiply per cycle, result stored to t (steps 0–4) or y (step 5). Sequence:
    - step 0: t←rb·rb (b²)
    - step 1: t←t·rb (b³)
    - step 2: t←t·t (b⁶)
    - step 3: t←t·rb (b⁷)
    - step 4: t←t·t (b¹⁴)
    - step 5: y←ra·t, then go to DONE.
  - DONE: out_valid=1, and y and div_zero are held stable. On out_ready, go to IDLE.
- Multiplier operands are muxed by step:
  - left operand: rb (step 0), t (steps 1–4), ra (step 5)
  - right operand: rb (steps 0, 1, 3), t (steps 2, 4, 5)
- div_zero is registered at acceptance as (b==0).
- For the early-zero path, y is forced to 4'h0.
- With EARLY_ZERO=0 and b=0, the chain naturally yields y=0, and div_zero=1 is still reported.
- a=0 with b≠0 runs normally and gives y=0 with div_zero=0.
- No result is dropped. A new operand is never accepted before the current result is taken.
- Step counter: 3 bits. Values 6–7 are unreachable; if reached, they force DONE with y unchanged.

## Timing

- Reset values, all asynchronous: state=IDLE, in_ready=1, out_valid=0, y=4'h0, div_zero=0, t=0, step=0, ra=0, rb=0.
- Latency:
  - Acceptance is the edge k where in_valid & in_ready.
  - Normal path: out_valid rises after edge k+6.
  - EARLY_ZERO path: out_valid rises after edge k+1.
- Result hold: out_valid stays high, with y stable, until an edge where out_ready=1. out_valid then drops on that edge.
- in_ready is combinational from state (IDLE only). It does not depend on out_ready.
- Throughput:
  - Best case, one division per 8 cycles: accept, 6×RUN, DONE with out_ready already high.
  - EARLY_ZERO, one per 2 cycles.
- in_valid asserted while busy is ignored. The source must hold a and b until in_ready.
- Reset asserted mid-RUN or in DONE aborts immediately. Any pending result is lost, and out_valid is 0 on the next observation.

## Structure

- Package gf16_div_pkg contains:
  - state enum {IDLE, RUN, DONE}
  - step constants STEP_SQ=0, STEP_CUBE=1, STEP_SQ6=2, STEP_SEV=3, STEP_SQ14=4, STEP_FIN=5
  - GF16_ONE=4'hF, GF16_ZERO=4'h0
- One sub-module instance: Mult_GF16, with constant input c tied to 4'h0 and constant addition disabled. There is a single instance, time-multiplexed over all steps.
- FSM, step counter and operand muxes live in gf16_serial_div.

## Test plan

- Reset → in_ready=1, out_valid=0, y=0, div_zero=0.
- a=4'hF, b=4'h1 accepted at edge k → out_valid after k+6, y=4'hC, div_zero=0.
- a=4'h1, b=4'hC → y=4'h7 (b⁻¹=1, and 1·1=7).
- Identity and zero operands:
  - All nonzero a with b=a → y=4'hF.
  - a=0, b=4'h5 → y=0, div_zero=0.
- a=4'h9, b=0:
  - EARLY_ZERO=1 → out_valid after k+1, y=0, div_zero=1.
  - EARLY_ZERO=0 → out_valid after k+6, same values.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles in DONE → y stable, in_ready=0, new in_valid ignored.
  - Assert rst at step 3 → next cycle in IDLE, out_valid=0, and no stale result appears.
